// File: rtl/decode_hold_pkg.sv
// Shared types and constants for the registered 2-to-4 decoder with hold/gap timing.
package decode_hold_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam logic [1:0] CODE_A = 2'b11;
    localparam logic [1:0] CODE_B = 2'b10;
    localparam logic [1:0] CODE_C = 2'b01;
    localparam logic [1:0] CODE_D = 2'b00;

endpackage

// File: rtl/decode_hold_if.sv
// Encoder-side code bundle in, decoded lines and status out.
interface decode_hold_if #(
    parameter int CNT_W = 8
);
    logic             e0;
    logic             e1;
    logic             nr;
    logic             a;
    logic             b;
    logic             c;
    logic             d;
    logic             busy;
    logic             drop;
    logic [CNT_W-1:0] evt_cnt;

    modport master (
        output e0, e1, nr,
        input  a, b, c, d, busy, drop, evt_cnt
    );

    modport slave (
        input  e0, e1, nr,
        output a, b, c, d, busy, drop, evt_cnt
    );
endinterface

// File: rtl/decode_hold_dec2to4.sv
// Combinational 2-to-4 one-hot decode; line index equals the code value.
module dec2to4
    import decode_hold_pkg::*;
(
    input  logic       en_i,
    input  logic [1:0] code_i,
    output logic [3:0] line_o
);
    always_comb begin
        line_o = 4'b0000;
        if (en_i) begin
            case (code_i)
                CODE_A:  line_o = 4'b1000;
                CODE_B:  line_o = 4'b0100;
                CODE_C:  line_o = 4'b0010;
                CODE_D:  line_o = 4'b0001;
                default: line_o = 4'b0000;
            endcase
        end
    end
endmodule

// File: rtl/decode_hold.sv
// Registered decoder: each accepted code drives one line for HOLD_CYC cycles, then a one-cycle gap.
// Conflicting codes seen while holding are discarded and flagged with a drop pulse.
module decode_hold
    import decode_hold_pkg::*;
#(
    parameter int HOLD_CYC = 4,
    parameter int CNT_W    = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    decode_hold_if.slave bus
);
    localparam int             HCW       = $clog2(HOLD_CYC + 1);
    localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYC - 1);

    state_e           state_q, state_d;
    logic [HCW-1:0]   hold_q, hold_d;
    logic [1:0]       code_q, code_d;
    logic [3:0]       line_q, line_d;
    logic             busy_q, busy_d;
    logic             drop_q, drop_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             req;
    logic [1:0]       req_code;
    logic [3:0]       dec_line;

    assign req      = ~bus.nr;
    assign req_code = {bus.e1, bus.e0};

    dec2to4 u_dec (
        .en_i   (req),
        .code_i (req_code),
        .line_o (dec_line)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        code_d  = code_q;
        line_d  = line_q;
        drop_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, GAP: begin
                if (req) begin
                    code_d  = req_code;
                    line_d  = dec_line;
                    hold_d  = HOLD_LOAD;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = HOLD;
                end else begin
                    line_d  = 4'b0000;
                    state_d = IDLE;
                end
            end
            HOLD: begin
                // Same-code requests are absorbed; only a different code is a conflict.
                if (req && (req_code != code_q)) begin
                    drop_d = 1'b1;
                end
                if (hold_q == '0) begin
                    line_d  = 4'b0000;
                    state_d = GAP;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: begin
                line_d  = 4'b0000;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            code_q  <= 2'b00;
            line_q  <= 4'b0000;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            code_q  <= code_d;
            line_q  <= line_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.a       = line_q[3];
    assign bus.b       = line_q[2];
    assign bus.c       = line_q[1];
    assign bus.d       = line_q[0];
    assign bus.busy    = busy_q;
    assign bus.drop    = drop_q;
    assign bus.evt_cnt = cnt_q;
endmodule

// File: tb/tb_decode_hold.sv
// Bench for decode_hold: timeline reference model plus directed scenarios and a loopback wrap case.
module tb_decode_hold;
    localparam int H = 4;

    logic clk;
    logic rst_n;
    logic clk_en;

    decode_hold_if #(.CNT_W(8)) bus ();
    decode_hold_if #(.CNT_W(2)) bus2 ();

    decode_hold #(.HOLD_CYC(H), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    decode_hold #(.HOLD_CYC(1), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: an event accepted at edge k owns edges k..k+H-1 for its line, blocks acceptance up to edge k+H.
    int         edge_n;
    int         acc_edge;
    logic [1:0] acc_code;
    int         exp_cnt;
    logic [3:0] exp_lines;
    logic       exp_busy;
    logic       exp_drop;

    task automatic model_reset();
        acc_edge  = -100;
        acc_code  = 2'b00;
        exp_cnt   = 0;
        exp_lines = 4'b0000;
        exp_busy  = 1'b0;
        exp_drop  = 1'b0;
    endtask

    task automatic cycle(input logic req_nr, input logic [1:0] code);
        bit on;
        bus.nr = req_nr;
        bus.e1 = code[1];
        bus.e0 = code[0];
        @(posedge clk);
        edge_n++;
        exp_drop = 1'b0;
        if (!req_nr) begin
            if (edge_n >= acc_edge + H + 1) begin
                acc_edge = edge_n;
                acc_code = code;
                exp_cnt  = (exp_cnt + 1) % 256;
            end else if (code != acc_code) begin
                exp_drop = 1'b1;
            end
        end
        on        = (edge_n >= acc_edge) && (edge_n <= acc_edge + H - 1);
        exp_lines = on ? (4'b0001 << acc_code) : 4'b0000;
        exp_busy  = on;
        #1;
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        clk_en  = 1'b0;
        bus.nr  = 1'b1; bus.e1 = 1'b0; bus.e0 = 1'b0;
        bus2.nr = 1'b1; bus2.e1 = 1'b0; bus2.e0 = 1'b0;
        rst_n   = 1'b0;
        #5;
        tests++;
        if ({bus.a, bus.b, bus.c, bus.d, bus.busy, bus.drop} !== 6'b0 || bus.evt_cnt !== 8'd0) begin
            fails++;
            $display("FAIL reset outs=%b cnt=%0d expected 000000 / 0",
                     {bus.a, bus.b, bus.c, bus.d, bus.busy, bus.drop}, bus.evt_cnt);
        end
        tests++;
        if ({bus2.a, bus2.b, bus2.c, bus2.d, bus2.busy, bus2.drop} !== 6'b0 || bus2.evt_cnt !== 2'd0) begin
            fails++;
            $display("FAIL reset2 outs=%b cnt=%0d expected 000000 / 0",
                     {bus2.a, bus2.b, bus2.c, bus2.d, bus2.busy, bus2.drop}, bus2.evt_cnt);
        end
        rst_n  = 1'b1;
        edge_n = 0;
        model_reset();
        #2 clk_en = 1'b1;
    endtask

    task automatic test_single();
        int a_hi = 0;
        cycle(1'b0, 2'b11);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) cycle(1'b1, 2'b00);
            a_hi += bus.a;
            tests++;
            if ({bus.a, bus.b, bus.c, bus.d, bus.busy, bus.drop} !== {exp_lines, exp_busy, exp_drop}) begin
                fails++;
                $display("FAIL single[%0d] outs=%b expected %b", i,
                         {bus.a, bus.b, bus.c, bus.d, bus.busy, bus.drop}, {exp_lines, exp_busy, exp_drop});
            end
        end
        tests++;
        if (a_hi !== 4 || bus.evt_cnt !== 8'd1) begin
            fails++;
            $display("FAIL single_total a_high=%0d cnt=%0d expected 4 / 1", a_hi, bus.evt_cnt);
        end
    endtask

    task automatic test_held();
        int b_hi = 0, drops = 0;
        apply_reset();
        for (int i = 0; i < 15; i++) begin
            cycle(1'b0, 2'b10);
            b_hi  += bus.b;
            drops += bus.drop;
            tests++;
            if ({bus.a, bus.b, bus.c, bus.d, bus.busy, bus.drop} !== {exp_lines, exp_busy, exp_drop}) begin
                fails++;
                $display("FAIL held[%0d] outs=%b expected %b", i,
                         {bus.a, bus.b, bus.c, bus.d, bus.busy, bus.drop}, {exp_lines, exp_busy, exp_drop});
            end
        end
        tests++;
        if (b_hi !== 12 || drops !== 0 || bus.evt_cnt !== 8'd3) begin
            fails++;
            $display("FAIL held_total b_high=%0d drops=%0d cnt=%0d expected 12 / 0 / 3", b_hi, drops, bus.evt_cnt);
        end
        repeat (3) cycle(1'b1, 2'b00);
    endtask

    task automatic test_conflict();
        int c_hi = 0, d_hi = 0, drops = 0;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            if (i == 0) cycle(1'b0, 2'b01);
            else if (i == 2) cycle(1'b0, 2'b00);
            else cycle(1'b1, 2'b00);
            c_hi  += bus.c;
            d_hi  += bus.d;
            drops += bus.drop;
            tests++;
            if ({bus.a, bus.b, bus.c, bus.d, bus.busy, bus.drop} !== {exp_lines, exp_busy, exp_drop}) begin
                fails++;
                $display("FAIL conflict[%0d] outs=%b expected %b", i,
                         {bus.a, bus.b, bus.c, bus.d, bus.busy, bus.drop}, {exp_lines, exp_busy, exp_drop});
            end
        end
        tests++;
        if (c_hi !== 4 || d_hi !== 0 || drops !== 1 || bus.evt_cnt !== 8'd1) begin
            fails++;
            $display("FAIL conflict_total c=%0d d=%0d drops=%0d cnt=%0d expected 4 / 0 / 1 / 1",
                     c_hi, d_hi, drops, bus.evt_cnt);
        end
    endtask

    task automatic test_reset_mid_hold();
        apply_reset();
        cycle(1'b0, 2'b10);
        cycle(1'b1, 2'b00);
        tests++;
        if (bus.b !== 1'b1) begin
            fails++;
            $display("FAIL midhold_pre b=%b expected 1", bus.b);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (bus.b !== 1'b0 || bus.busy !== 1'b0 || bus.evt_cnt !== 8'd0) begin
            fails++;
            $display("FAIL midhold_async b=%b busy=%b cnt=%0d expected 0 / 0 / 0", bus.b, bus.busy, bus.evt_cnt);
        end
        #2 rst_n = 1'b1;
        model_reset();
        cycle(1'b1, 2'b00);
        for (int i = 0; i < 6; i++) begin
            if (i == 0) cycle(1'b0, 2'b11);
            else cycle(1'b1, 2'b00);
            tests++;
            if ({bus.a, bus.b, bus.c, bus.d, bus.busy, bus.drop} !== {exp_lines, exp_busy, exp_drop}
                || bus.evt_cnt !== 8'(exp_cnt)) begin
                fails++;
                $display("FAIL midhold_after[%0d] outs=%b cnt=%0d expected %b / %0d", i,
                         {bus.a, bus.b, bus.c, bus.d, bus.busy, bus.drop}, bus.evt_cnt,
                         {exp_lines, exp_busy, exp_drop}, exp_cnt);
            end
        end
    endtask

    task automatic test_random();
        logic       r_nr;
        logic [1:0] r_code;
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            r_nr   = ($urandom_range(0, 2) == 0);
            r_code = 2'($urandom_range(0, 3));
            cycle(r_nr, r_code);
            tests++;
            if ({bus.a, bus.b, bus.c, bus.d, bus.busy, bus.drop} !== {exp_lines, exp_busy, exp_drop}
                || bus.evt_cnt !== 8'(exp_cnt)) begin
                fails++;
                $display("FAIL random[%0d] outs=%b cnt=%0d expected %b / %0d", i,
                         {bus.a, bus.b, bus.c, bus.d, bus.busy, bus.drop}, bus.evt_cnt,
                         {exp_lines, exp_busy, exp_drop}, exp_cnt);
            end
        end
        cycle(1'b1, 2'b00);
    endtask

    // Loopback: one-hot {a,b,c,d} -> encoder bundle -> narrow decoder (HOLD_CYC=1, CNT_W=2).
    task automatic test_loopback_wrap();
        logic [3:0] src;
        logic [3:0] want;
        logic [2:0] enc;
        bus.nr = 1'b1;
        apply_reset();
        for (int ev = 0; ev < 4; ev++) begin
            src = 4'b1000 >> ev;
            for (int k = 0; k < 3; k++) begin
                case (k == 0 ? src : 4'b0000)
                    4'b1000: enc = 3'b011;
                    4'b0100: enc = 3'b010;
                    4'b0010: enc = 3'b001;
                    4'b0001: enc = 3'b000;
                    default: enc = 3'b100;
                endcase
                bus2.nr = enc[2];
                bus2.e1 = enc[1];
                bus2.e0 = enc[0];
                @(posedge clk);
                #1;
                want = (k == 0) ? src : 4'b0000;
                tests++;
                if ({bus2.a, bus2.b, bus2.c, bus2.d} !== want || bus2.busy !== (k == 0)
                    || bus2.evt_cnt !== 2'((ev + 1) % 4)) begin
                    fails++;
                    $display("FAIL loop[%0d.%0d] lines=%b busy=%b cnt=%0d expected %b / %b / %0d", ev, k,
                             {bus2.a, bus2.b, bus2.c, bus2.d}, bus2.busy, bus2.evt_cnt,
                             want, (k == 0), (ev + 1) % 4);
                end
            end
        end
        tests++;
        if (bus2.evt_cnt !== 2'd0) begin
            fails++;
            $display("FAIL loop_wrap cnt=%0d expected 0", bus2.evt_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_held();
        test_conflict();
        test_reset_mid_hold();
        test_random();
        test_loopback_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
